// File: rtl/eth_rx_frame_filter.sv
// rtl/eth_rx_frame_filter.sv - RX destination-MAC filter with runt/oversize marking and per-frame status pulses.
// A 6-byte delay buffer holds the header until the address decision, then streams through it.
module eth_rx_frame_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic [47:0]           cfg_local_mac,
  input  logic                  cfg_promisc,
  input  logic                  cfg_bcast_enable,
  input  logic                  cfg_mcast_enable,
  output logic                  stat_rx_good,
  output logic                  stat_rx_bad,
  output logic                  stat_rx_filtered,
  output logic                  stat_rx_runt,
  output logic                  stat_rx_oversize
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_rx_frame_filter: only DATA_WIDTH=8 is supported");
  end
  if (MAX_LEN <= 6) begin : g_bad_max
    $error("eth_rx_frame_filter: MAX_LEN must be greater than 6");
  end

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] OVR_L = 16'(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, HEADER, PASS, FLUSH, DROP} state_t;

  state_t          state_q;
  logic [5:0][7:0] hdr_q;
  logic [15:0]     count_q;
  logic [2:0]      flush_q;
  logic            in_frame_q;
  logic            final_q;
  logic            runt_q;

  logic [47:0] dst_d;
  logic        is_bcast_d;
  logic        accept_d;
  logic [15:0] count_d;
  logic        short_d;
  logic        in_frame_d;

  always_comb begin
    dst_d      = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis_tdata};
    is_bcast_d = &dst_d;
    accept_d   = cfg_promisc || (dst_d == cfg_local_mac) ||
                 (cfg_bcast_enable && is_bcast_d) ||
                 (cfg_mcast_enable && dst_d[40] && !is_bcast_d);
    count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    short_d    = count_d < MIN_L;
    // Tracks input framing independently of the FSM so a reset or overrun mid-frame resyncs on tlast.
    in_frame_d = s_axis_tvalid ? !s_axis_tlast : in_frame_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      hdr_q            <= '0;
      count_q          <= '0;
      flush_q          <= '0;
      final_q          <= 1'b0;
      runt_q           <= 1'b0;
      in_frame_q       <= in_frame_d;
      m_axis_tdata     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser     <= 1'b0;
      stat_rx_good     <= 1'b0;
      stat_rx_bad      <= 1'b0;
      stat_rx_filtered <= 1'b0;
      stat_rx_runt     <= 1'b0;
      stat_rx_oversize <= 1'b0;
    end else begin
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser     <= 1'b0;
      stat_rx_good     <= 1'b0;
      stat_rx_bad      <= 1'b0;
      stat_rx_filtered <= 1'b0;
      stat_rx_runt     <= 1'b0;
      stat_rx_oversize <= 1'b0;
      in_frame_q       <= in_frame_d;

      case (state_q)
        IDLE: begin
          if (s_axis_tvalid) begin
            if (in_frame_q) begin
              if (!s_axis_tlast) state_q <= DROP;
            end else begin
              hdr_q[0] <= s_axis_tdata;
              count_q  <= 16'd1;
              if (s_axis_tlast) begin
                stat_rx_runt <= 1'b1;
                stat_rx_bad  <= 1'b1;
              end else begin
                state_q <= HEADER;
              end
            end
          end
        end

        HEADER: begin
          if (s_axis_tvalid) begin
            hdr_q[count_q[2:0]] <= s_axis_tdata;
            count_q             <= count_d;
            if (count_q == 16'd5) begin
              if (!accept_d) begin
                stat_rx_filtered <= 1'b1;
                state_q          <= s_axis_tlast ? IDLE : DROP;
              end else if (s_axis_tlast) begin
                final_q <= s_axis_tuser || short_d;
                runt_q  <= short_d;
                flush_q <= '0;
                state_q <= FLUSH;
              end else begin
                state_q <= PASS;
              end
            end else if (s_axis_tlast) begin
              stat_rx_runt <= 1'b1;
              stat_rx_bad  <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end

        PASS: begin
          if (s_axis_tvalid) begin
            count_q <= count_d;
            flush_q <= '0;
            if (count_d == OVR_L) begin
              stat_rx_oversize <= 1'b1;
              final_q          <= 1'b1;
              runt_q           <= 1'b0;
              state_q          <= FLUSH;
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= hdr_q[0];
              hdr_q         <= {s_axis_tdata, hdr_q[5:1]};
              if (s_axis_tlast) begin
                final_q <= s_axis_tuser || short_d;
                runt_q  <= short_d;
                state_q <= FLUSH;
              end
            end
          end
        end

        FLUSH: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= hdr_q[0];
          hdr_q         <= {8'h00, hdr_q[5:1]};
          flush_q       <= flush_q + 3'd1;
          // A beat after the input tlast belongs to a new frame that cannot be buffered.
          if (s_axis_tvalid && !in_frame_q) stat_rx_bad <= 1'b1;
          if (flush_q == 3'd5) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= final_q;
            stat_rx_good <= !final_q;
            if (final_q) stat_rx_bad <= 1'b1;
            stat_rx_runt <= runt_q;
            state_q      <= in_frame_d ? DROP : IDLE;
          end
        end

        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb/tb_eth_rx_frame_filter.sv - randomized self-checking bench for eth_rx_frame_filter.
// Expected output per frame comes from a frame-level model of the filter rules.
module tb_eth_rx_frame_filter;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam logic [47:0] LOCAL = 48'h00_0A_35_01_02_03;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] s_tdata;
  logic s_tvalid, s_tlast, s_tuser;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tlast, m_tuser;
  logic [47:0] cfg_local_mac;
  logic cfg_promisc, cfg_bcast_enable, cfg_mcast_enable;
  logic st_good, st_bad, st_filt, st_runt, st_ovs;

  always #5 clk = ~clk;

  eth_rx_frame_filter #(.DATA_WIDTH(8), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc),
    .cfg_bcast_enable(cfg_bcast_enable), .cfg_mcast_enable(cfg_mcast_enable),
    .stat_rx_good(st_good), .stat_rx_bad(st_bad), .stat_rx_filtered(st_filt),
    .stat_rx_runt(st_runt), .stat_rx_oversize(st_ovs)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_nlast, got_lastpos, first_in, first_out;
  logic got_user, exp_user;
  // Stat pulse counts: [0] good, [1] bad, [2] filtered, [3] runt, [4] oversize.
  logic [4:0][7:0] got_st, exp_st;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_tvalid) begin
      if (got_q.size() == 0) first_out = cyc;
      got_q.push_back(m_tdata);
      if (m_tlast) begin
        got_nlast++;
        got_lastpos = got_q.size();
        got_user = m_tuser;
      end
    end
    if (st_good) got_st[0] = got_st[0] + 8'd1;
    if (st_bad)  got_st[1] = got_st[1] + 8'd1;
    if (st_filt) got_st[2] = got_st[2] + 8'd1;
    if (st_runt) got_st[3] = got_st[3] + 8'd1;
    if (st_ovs)  got_st[4] = got_st[4] + 8'd1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles required finish", cyc);
    $fatal(1);
  end

  task automatic clear_capture();
    got_q.delete();
    got_nlast = 0; got_lastpos = 0; got_user = 1'b0;
    first_out = -1; first_in = -1;
    got_st = '0;
  endtask

  task automatic build_frame(input int n, input logic [47:0] dst);
    frame_q.delete();
    for (int i = 0; i < n; i++)
      frame_q.push_back(i < 6 ? dst[47-8*i -: 8] : 8'($urandom));
  endtask

  task automatic model(input bit user);
    int n;
    logic [47:0] dst;
    n = frame_q.size();
    exp_q.delete(); exp_st = '0; exp_user = 1'b0; dst = '0;
    if (n >= 6) dst = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    if (n < 6) begin
      exp_st[3] = 1; exp_st[1] = 1;
    end else if (!(cfg_promisc || dst == cfg_local_mac || (cfg_bcast_enable && dst == BCAST) ||
                   (cfg_mcast_enable && dst[40] && dst != BCAST))) begin
      exp_st[2] = 1;
    end else if (n > MAX_LEN) begin
      for (int i = 0; i < MAX_LEN; i++) exp_q.push_back(frame_q[i]);
      exp_user = 1'b1; exp_st[4] = 1; exp_st[1] = 1;
    end else begin
      exp_q = frame_q;
      exp_user = user || (n < MIN_LEN);
      if (exp_user) exp_st[1] = 1; else exp_st[0] = 1;
      if (n < MIN_LEN) exp_st[3] = 1;
    end
  endtask

  task automatic drive_frame(input bit user, input bit mii);
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) first_in = cyc;
      s_tvalid = 1'b1; s_tdata = frame_q[i];
      s_tlast = (i == frame_q.size() - 1);
      s_tuser = s_tlast & user;
      if (mii) begin
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic [47:0] dst, input bit user, input bit mii);
    clear_capture();
    build_frame(n, dst);
    model(user);
    drive_frame(user, mii);
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
  endtask

  function automatic int out_diffs();
    int d;
    d = 0;
    if (got_q.size() != exp_q.size()) return 1000000;
    for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_tvalid, m_tlast, m_tuser, m_tdata, st_good, st_bad, st_filt, st_runt, st_ovs} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {m_tvalid, m_tlast, m_tuser, m_tdata, st_good, st_bad, st_filt, st_runt, st_ovs});
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_unicast();
    run_frame(64, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0) begin n_fail++; $display("FAIL unicast_data: got %0d bytes required %0d (diffs %0d)", got_q.size(), exp_q.size(), out_diffs()); end
    n_cmp++; if (first_out - first_in != 7) begin n_fail++; $display("FAIL unicast_latency: got %0d required 7", first_out - first_in); end
    n_cmp++; if (got_nlast != 1 || got_lastpos != 64 || got_user !== 1'b0) begin n_fail++; $display("FAIL unicast_tlast: got n=%0d pos=%0d user=%b required 1/64/0", got_nlast, got_lastpos, got_user); end
    n_cmp++; if (got_st !== exp_st) begin n_fail++; $display("FAIL unicast_stats: got %h required %h", got_st, exp_st); end
  endtask

  task automatic test_filtered();
    run_frame(64, 48'h02_00_00_00_00_99, 1'b0, 1'b0);
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL filtered_data: got %0d beats required 0", got_q.size()); end
    n_cmp++; if (got_st !== exp_st) begin n_fail++; $display("FAIL filtered_stats: got %h required %h", got_st, exp_st); end
    run_frame($urandom_range(60, 200), LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0 || got_user !== 1'b0 || got_lastpos != exp_q.size()) begin n_fail++; $display("FAIL filtered_next: got %0d bytes user=%b required %0d user=0", got_q.size(), got_user, exp_q.size()); end
  endtask

  task automatic test_bcast_mcast();
    for (int en = 0; en < 2; en++) begin
      cfg_bcast_enable = en[0];
      run_frame(100, BCAST, 1'b0, 1'b0);
      n_cmp++; if (out_diffs() != 0 || got_st !== exp_st) begin n_fail++; $display("FAIL bcast_en%0d: got %0d beats stats %h required %0d stats %h", en, got_q.size(), got_st, exp_q.size(), exp_st); end
    end
    for (int en = 0; en < 2; en++) begin
      cfg_mcast_enable = en[0];
      run_frame(80, {24'h01_00_5E, 24'($urandom)}, 1'b0, 1'b0);
      n_cmp++; if (out_diffs() != 0 || got_st !== exp_st) begin n_fail++; $display("FAIL mcast_en%0d: got %0d beats stats %h required %0d stats %h", en, got_q.size(), got_st, exp_q.size(), exp_st); end
    end
    cfg_bcast_enable = 1'b0; cfg_mcast_enable = 1'b0;
  endtask

  task automatic test_runt();
    run_frame(40, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0 || got_lastpos != 40 || got_user !== 1'b1) begin n_fail++; $display("FAIL runt40_data: got %0d beats user=%b required 40 user=1", got_q.size(), got_user); end
    n_cmp++; if (got_st !== exp_st) begin n_fail++; $display("FAIL runt40_stats: got %h required %h", got_st, exp_st); end
    run_frame(4, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (got_q.size() != 0 || got_st !== exp_st) begin n_fail++; $display("FAIL runt4: got %0d beats stats %h required 0 stats %h", got_q.size(), got_st, exp_st); end
    run_frame(6, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0 || got_user !== 1'b1 || got_st !== exp_st) begin n_fail++; $display("FAIL runt6: got %0d beats user=%b stats %h required 6 user=1 stats %h", got_q.size(), got_user, got_st, exp_st); end
  endtask

  task automatic test_oversize();
    run_frame(1600, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0 || got_nlast != 1 || got_lastpos != MAX_LEN || got_user !== 1'b1) begin n_fail++; $display("FAIL oversize_data: got %0d beats last@%0d user=%b required %0d user=1", got_q.size(), got_lastpos, got_user, MAX_LEN); end
    n_cmp++; if (got_st !== exp_st) begin n_fail++; $display("FAIL oversize_stats: got %h required %h", got_st, exp_st); end
    run_frame(64, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0 || got_user !== 1'b0 || got_st !== exp_st) begin n_fail++; $display("FAIL oversize_next: got %0d beats user=%b stats %h required 64 user=0 stats %h", got_q.size(), got_user, got_st, exp_st); end
  endtask

  task automatic test_mii();
    run_frame(64, LOCAL, 1'b1, 1'b1);
    n_cmp++; if (out_diffs() != 0 || got_lastpos != 64 || got_user !== 1'b1) begin n_fail++; $display("FAIL mii_data: got %0d beats user=%b required 64 user=1", got_q.size(), got_user); end
    n_cmp++; if (got_st !== exp_st) begin n_fail++; $display("FAIL mii_stats: got %h required %h", got_st, exp_st); end
  endtask

  task automatic test_reset_mid_frame();
    clear_capture();
    build_frame(100, LOCAL);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 31) begin
        n_cmp++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 11'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h required 0", {m_tvalid, m_tlast, m_tuser, m_tdata}); end
        clear_capture();
      end
      rst = (i == 30);
      s_tvalid = 1'b1; s_tdata = frame_q[i]; s_tlast = (i == 99); s_tuser = 1'b0;
    end
    @(posedge clk); #1; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (got_q.size() != 0 || got_st !== '0) begin n_fail++; $display("FAIL rst_mid_drop: got %0d beats stats %h required 0", got_q.size(), got_st); end
    run_frame(70, LOCAL, 1'b0, 1'b0);
    n_cmp++; if (out_diffs() != 0 || got_st !== exp_st) begin n_fail++; $display("FAIL rst_mid_next: got %0d beats stats %h required %0d stats %h", got_q.size(), got_st, exp_q.size(), exp_st); end
  endtask

  task automatic test_random();
    logic [47:0] dst;
    int n;
    bit mii, user;
    for (int k = 0; k < 30; k++) begin
      cfg_promisc = ($urandom_range(0, 4) == 0);
      cfg_bcast_enable = 1'($urandom);
      cfg_mcast_enable = 1'($urandom);
      case ($urandom_range(0, 4))
        0: dst = LOCAL;
        1: dst = BCAST;
        2: dst = {24'h01_00_5E, 24'($urandom)};
        3: dst = {8'h02, 40'($urandom)};
        default: dst = {LOCAL[47:8], 8'($urandom)};
      endcase
      case ($urandom_range(0, 7))
        0, 1: n = $urandom_range(1, 8);
        2, 3: n = $urandom_range(55, 66);
        4: n = $urandom_range(MAX_LEN - 3, MAX_LEN + 4);
        default: n = $urandom_range(6, 200);
      endcase
      mii = (n < 300) && 1'($urandom);
      user = ($urandom_range(0, 3) == 0);
      run_frame(n, dst, user, mii);
      n_cmp++; if (out_diffs() != 0) begin n_fail++; $display("FAIL rand%0d_data: got %0d beats required %0d (n=%0d dst=%h)", k, got_q.size(), exp_q.size(), n, dst); end
      n_cmp++; if (got_st !== exp_st) begin n_fail++; $display("FAIL rand%0d_stats: got %h required %h (n=%0d dst=%h)", k, got_st, exp_st, n, dst); end
      n_cmp++; if (got_nlast != (exp_q.size() > 0 ? 1 : 0) || got_lastpos != exp_q.size() || got_user !== exp_user) begin n_fail++; $display("FAIL rand%0d_tlast: got n=%0d pos=%0d user=%b required pos=%0d user=%b", k, got_nlast, got_lastpos, got_user, exp_q.size(), exp_user); end
    end
    cfg_promisc = 1'b0; cfg_bcast_enable = 1'b0; cfg_mcast_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    cfg_local_mac = LOCAL;
    cfg_promisc = 1'b0; cfg_bcast_enable = 1'b0; cfg_mcast_enable = 1'b0;
    clear_capture();
    test_reset();
    test_unicast();
    test_filtered();
    test_bcast_mcast();
    test_runt();
    test_oversize();
    test_mii();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
